// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I control unit.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt,
        StFault
    } state_e;

    typedef enum logic [2:0] {
        ClsAlu,
        ClsBranch,
        ClsJump,
        ClsLoad,
        ClsStore,
        ClsSystem,
        ClsIllegal
    } opclass_e;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] ALU_SRC_REG = 2'd0;
    localparam logic [1:0] ALU_SRC_IMM = 2'd1;
    localparam logic [1:0] ALU_SRC_PC  = 2'd2;
    localparam logic [1:0] ALU_SRC_NPC = 2'd3;

endpackage

// File: rtl/ctrl_opdecode.sv
// Combinational opcode decoder: static datapath controls plus an opclass for sequencing.
module ctrl_opdecode
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    output logic [1:0] alusrc,
    output logic       alusrc_a_zero,
    output logic       jumpsrc,
    output logic [2:0] memsize,
    output opclass_e   opclass
);

    // Map the latched opcode to its static control word; unknown opcodes decode to all-zero.
    always_comb begin
        alusrc        = ALU_SRC_REG;
        alusrc_a_zero = 1'b0;
        jumpsrc       = 1'b0;
        memsize       = 3'b000;
        opclass       = ClsIllegal;
        case (op)
            OP_AUIPC: begin
                alusrc        = ALU_SRC_PC;
                alusrc_a_zero = 1'b1;
                opclass       = ClsAlu;
            end
            OP_LUI: begin
                alusrc        = ALU_SRC_IMM;
                alusrc_a_zero = 1'b1;
                opclass       = ClsAlu;
            end
            OP_IMM: begin
                alusrc  = ALU_SRC_IMM;
                opclass = ClsAlu;
            end
            OP_OP: begin
                opclass = ClsAlu;
            end
            OP_BRANCH: begin
                opclass = ClsBranch;
            end
            OP_JAL: begin
                alusrc        = ALU_SRC_NPC;
                alusrc_a_zero = 1'b1;
                opclass       = ClsJump;
            end
            OP_JALR: begin
                alusrc        = ALU_SRC_NPC;
                alusrc_a_zero = 1'b1;
                jumpsrc       = 1'b1;
                opclass       = ClsJump;
            end
            OP_LOAD: begin
                alusrc  = ALU_SRC_IMM;
                memsize = funct3;
                opclass = ClsLoad;
            end
            OP_STORE: begin
                alusrc  = ALU_SRC_IMM;
                memsize = funct3;
                opclass = ClsStore;
            end
            OP_SYSTEM: begin
                opclass = ClsSystem;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB with memory handshakes, timeouts,
// sticky halt/fault and a retired-instruction counter.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT     = 16,
    parameter int unsigned TO_W            = 8,
    parameter int unsigned CNT_W           = 32,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       instr_op,
    input  logic [2:0]       instr_funct3,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             irwrite,
    output logic             dmem_req,
    output logic             memwrite,
    output logic             memtoreg,
    output logic [2:0]       memsize,
    output logic [1:0]       alusrc,
    output logic             alusrc_a_zero,
    output logic             branch,
    output logic             jump,
    output logic             jumpsrc,
    output logic             regwrite,
    output logic             pcwrite,
    output logic             retire,
    output logic             hlt,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] instret
);

    localparam bit TimeoutEn = (MEM_TIMEOUT != 0);

    state_e            state_q, state_d;
    logic [6:0]        op_q, op_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [TO_W-1:0]   wait_q, wait_d;
    logic [1:0]        fault_q, fault_d;
    logic [CNT_W-1:0]  instret_q, instret_d;

    logic [1:0]        dec_alusrc;
    logic              dec_a_zero;
    logic              dec_jumpsrc;
    logic [2:0]        dec_memsize;
    opclass_e          dec_class;
    logic              statics_on;
    logic              timeout_hit;

    ctrl_opdecode u_opdecode (
        .op            (op_q),
        .funct3        (funct3_q),
        .alusrc        (dec_alusrc),
        .alusrc_a_zero (dec_a_zero),
        .jumpsrc       (dec_jumpsrc),
        .memsize       (dec_memsize),
        .opclass       (dec_class)
    );

    // Ready in the same cycle as the limit takes priority over the timeout.
    assign timeout_hit = TimeoutEn && (wait_q == TO_W'(MEM_TIMEOUT));

    // Next-state, datapath strobes and static controls.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        funct3_d      = funct3_q;
        wait_d        = wait_q;
        fault_d       = fault_q;
        imem_req      = 1'b0;
        irwrite       = 1'b0;
        dmem_req      = 1'b0;
        memwrite      = 1'b0;
        memtoreg      = 1'b0;
        branch        = 1'b0;
        jump          = 1'b0;
        regwrite      = 1'b0;
        pcwrite       = 1'b0;
        retire        = 1'b0;
        hlt           = 1'b0;
        statics_on    = 1'b0;
        memsize       = 3'b000;
        alusrc        = ALU_SRC_REG;
        alusrc_a_zero = 1'b0;
        jumpsrc       = 1'b0;

        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    irwrite  = 1'b1;
                    op_d     = instr_op;
                    funct3_d = instr_funct3;
                    state_d  = StDecode;
                end else if (timeout_hit) begin
                    fault_d = FAULT_TIMEOUT;
                    state_d = StFault;
                end else if (TimeoutEn) begin
                    wait_d = wait_q + TO_W'(1);
                end
            end
            StDecode: begin
                statics_on = 1'b1;
                case (dec_class)
                    ClsIllegal: begin
                        if (HALT_ON_ILLEGAL) begin
                            fault_d = FAULT_ILLEGAL;
                            state_d = StFault;
                        end else begin
                            state_d = StExec;
                        end
                    end
                    ClsSystem: state_d = StHalt;
                    default:   state_d = StExec;
                endcase
            end
            StExec: begin
                statics_on = 1'b1;
                case (dec_class)
                    ClsBranch: begin
                        branch  = 1'b1;
                        pcwrite = 1'b1;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    // Only reachable when illegal opcodes retire as NOPs.
                    ClsIllegal: begin
                        pcwrite = 1'b1;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    ClsLoad, ClsStore: state_d = StMem;
                    default:           state_d = StWb;
                endcase
            end
            StMem: begin
                statics_on = 1'b1;
                dmem_req   = 1'b1;
                memwrite   = (dec_class == ClsStore);
                if (dmem_ready) begin
                    if (dec_class == ClsStore) begin
                        pcwrite = 1'b1;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (timeout_hit) begin
                    fault_d = FAULT_TIMEOUT;
                    state_d = StFault;
                end else if (TimeoutEn) begin
                    wait_d = wait_q + TO_W'(1);
                end
            end
            StWb: begin
                statics_on = 1'b1;
                regwrite   = 1'b1;
                pcwrite    = 1'b1;
                retire     = 1'b1;
                memtoreg   = (dec_class == ClsLoad);
                jump       = (dec_class == ClsJump);
                state_d    = StFetch;
            end
            StHalt:  hlt = 1'b1;
            StFault: hlt = 1'b1;
        endcase

        // Each memory wait phase starts counting from zero.
        if ((state_d != state_q) && ((state_d == StFetch) || (state_d == StMem))) begin
            wait_d = '0;
        end

        if (statics_on) begin
            memsize       = dec_memsize;
            alusrc        = dec_alusrc;
            alusrc_a_zero = dec_a_zero;
            jumpsrc       = dec_jumpsrc;
        end

        instret_d = instret_q + CNT_W'(retire);
    end

    assign fault   = fault_q;
    assign instret = instret_q;

    // State and architectural registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= '0;
            funct3_q  <= '0;
            wait_q    <= '0;
            fault_q   <= FAULT_NONE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            funct3_q  <= funct3_d;
            wait_q    <= wait_d;
            fault_q   <= fault_d;
            instret_q <= instret_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level model expands each instruction into
// per-cycle {inputs, expected outputs} rows that are then applied and compared.
module tb_multicycle_ctrl;

    // Packed output vector, MSB first in this field order.
    typedef struct packed {
        logic       imem_req;
        logic       irwrite;
        logic       dmem_req;
        logic       memwrite;
        logic       memtoreg;
        logic [2:0] memsize;
        logic [1:0] alusrc;
        logic       a_zero;
        logic       branch;
        logic       jump;
        logic       jumpsrc;
        logic       regwrite;
        logic       pcwrite;
        logic       retire;
        logic       hlt;
        logic [1:0] fault;
    } outs_t;

    typedef struct {
        logic       ir;
        logic       dr;
        logic [6:0] op;
        logic [2:0] f3;
        outs_t      exp;
    } vec_t;

    logic clk;
    logic reset;
    logic [6:0] instr_op;
    logic [2:0] instr_funct3;
    logic imem_ready, dmem_ready;

    logic a_imem_req, a_irwrite, a_dmem_req, a_memwrite, a_memtoreg, a_azero, a_branch;
    logic a_jump, a_jumpsrc, a_regwrite, a_pcwrite, a_retire, a_hlt;
    logic [2:0] a_memsize;
    logic [1:0] a_alusrc, a_fault;
    logic [31:0] a_instret;
    logic b_imem_req, b_irwrite, b_dmem_req, b_memwrite, b_memtoreg, b_azero, b_branch;
    logic b_jump, b_jumpsrc, b_regwrite, b_pcwrite, b_retire, b_hlt;
    logic [2:0] b_memsize;
    logic [1:0] b_alusrc, b_fault;
    logic [3:0] b_instret;

    outs_t act_a, act_b;

    vec_t        vq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          sel;
    int          cur_to;
    bit          cur_hoi;
    logic [31:0] exp_cnt;
    logic [31:0] cnt_mask;
    string       phase;
    logic [6:0]  pool_a[0:8];
    logic [6:0]  pool_b[0:10];

    // Config A: timeout 4, illegal faults, 32-bit counter.
    multicycle_ctrl #(
        .MEM_TIMEOUT(4), .TO_W(8), .CNT_W(32), .HALT_ON_ILLEGAL(1'b1)
    ) u_dut_a (
        .clk(clk), .reset(reset), .instr_op(instr_op), .instr_funct3(instr_funct3),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(a_imem_req),
        .irwrite(a_irwrite), .dmem_req(a_dmem_req), .memwrite(a_memwrite),
        .memtoreg(a_memtoreg), .memsize(a_memsize), .alusrc(a_alusrc),
        .alusrc_a_zero(a_azero), .branch(a_branch), .jump(a_jump), .jumpsrc(a_jumpsrc),
        .regwrite(a_regwrite), .pcwrite(a_pcwrite), .retire(a_retire), .hlt(a_hlt),
        .fault(a_fault), .instret(a_instret)
    );

    // Config B: timeout disabled, illegal retires as NOP, 4-bit counter to exercise wrap.
    multicycle_ctrl #(
        .MEM_TIMEOUT(0), .TO_W(8), .CNT_W(4), .HALT_ON_ILLEGAL(1'b0)
    ) u_dut_b (
        .clk(clk), .reset(reset), .instr_op(instr_op), .instr_funct3(instr_funct3),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(b_imem_req),
        .irwrite(b_irwrite), .dmem_req(b_dmem_req), .memwrite(b_memwrite),
        .memtoreg(b_memtoreg), .memsize(b_memsize), .alusrc(b_alusrc),
        .alusrc_a_zero(b_azero), .branch(b_branch), .jump(b_jump), .jumpsrc(b_jumpsrc),
        .regwrite(b_regwrite), .pcwrite(b_pcwrite), .retire(b_retire), .hlt(b_hlt),
        .fault(b_fault), .instret(b_instret)
    );

    assign act_a = {a_imem_req, a_irwrite, a_dmem_req, a_memwrite, a_memtoreg, a_memsize,
                    a_alusrc, a_azero, a_branch, a_jump, a_jumpsrc, a_regwrite, a_pcwrite,
                    a_retire, a_hlt, a_fault};
    assign act_b = {b_imem_req, b_irwrite, b_dmem_req, b_memwrite, b_memtoreg, b_memsize,
                    b_alusrc, b_azero, b_branch, b_jump, b_jumpsrc, b_regwrite, b_pcwrite,
                    b_retire, b_hlt, b_fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push(input logic ir, input logic dr, input logic [6:0] op,
                                 input logic [2:0] f3, input outs_t e);
        vec_t v;
        v.ir  = ir;
        v.dr  = dr;
        v.op  = op;
        v.f3  = f3;
        v.exp = e;
        vq.push_back(v);
    endfunction

    // Row whose inputs must be ignored by the DUT.
    function automatic void push_any(input outs_t e);
        push(1'($urandom), 1'($urandom), 7'($urandom), 3'($urandom), e);
    endfunction

    function automatic void push_term(input logic [1:0] code);
        outs_t e;
        e       = '0;
        e.hlt   = 1'b1;
        e.fault = code;
        for (int k = 0; k < 3; k++) push_any(e);
    endfunction

    // Static controls straight from the opcode table.
    function automatic outs_t statics(input logic [6:0] op, input logic [2:0] f3);
        outs_t o;
        o = '0;
        case (op)
            7'b0010111: begin o.alusrc = 2'd2; o.a_zero = 1'b1; end
            7'b0110111: begin o.alusrc = 2'd1; o.a_zero = 1'b1; end
            7'b0010011: o.alusrc = 2'd1;
            7'b1101111: begin o.alusrc = 2'd3; o.a_zero = 1'b1; end
            7'b1100111: begin o.alusrc = 2'd3; o.a_zero = 1'b1; o.jumpsrc = 1'b1; end
            7'b0000011, 7'b0100011: begin o.alusrc = 2'd1; o.memsize = f3; end
            default: ;
        endcase
        return o;
    endfunction

    // Expand one instruction (starting in FETCH) into expected cycles.
    function automatic void gen_instr(input logic [6:0] op, input logic [2:0] f3,
                                      input int fw, input int dw);
        outs_t e, st;
        bit is_ld, is_st, is_br, is_jmp, is_sys, legal;
        is_ld  = (op == 7'b0000011);
        is_st  = (op == 7'b0100011);
        is_br  = (op == 7'b1100011);
        is_jmp = (op == 7'b1101111) || (op == 7'b1100111);
        is_sys = (op == 7'b1110011);
        legal  = is_ld || is_st || is_br || is_jmp || is_sys ||
                 (op inside {7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011});
        for (int i = 0; i <= fw; i++) begin
            e          = '0;
            e.imem_req = 1'b1;
            if (i == fw) begin
                e.irwrite = 1'b1;
                push(1'b1, 1'($urandom), op, f3, e);
            end else begin
                push(1'b0, 1'($urandom), 7'($urandom), 3'($urandom), e);
                if (cur_to > 0 && i == cur_to) begin
                    push_term(2'd2);
                    return;
                end
            end
        end
        st = statics(op, f3);
        push_any(st);
        if (!legal && cur_hoi) begin
            push_term(2'd1);
            return;
        end
        if (is_sys) begin
            push_term(2'd0);
            return;
        end
        if (!legal || is_br) begin
            e         = st;
            e.branch  = is_br;
            e.pcwrite = 1'b1;
            e.retire  = 1'b1;
            push_any(e);
            return;
        end
        push_any(st);
        if (is_ld || is_st) begin
            for (int i = 0; i <= dw; i++) begin
                e          = st;
                e.dmem_req = 1'b1;
                e.memwrite = is_st;
                if (i == dw) begin
                    e.pcwrite = is_st;
                    e.retire  = is_st;
                    push(1'($urandom), 1'b1, 7'($urandom), 3'($urandom), e);
                end else begin
                    push(1'($urandom), 1'b0, 7'($urandom), 3'($urandom), e);
                    if (cur_to > 0 && i == cur_to) begin
                        push_term(2'd2);
                        return;
                    end
                end
            end
            if (is_st) return;
        end
        e          = st;
        e.regwrite = 1'b1;
        e.pcwrite  = 1'b1;
        e.retire   = 1'b1;
        e.memtoreg = is_ld;
        e.jump     = is_jmp;
        push_any(e);
    endfunction

    task automatic cmp_outs(input string what, input outs_t want);
        outs_t got;
        got = (sel != 0) ? act_b : act_a;
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s %s outs: got %b want %b", phase, what, got, want);
        end
    endtask

    task automatic cmp_cnt(input string what, input logic [31:0] want);
        logic [31:0] got;
        got = (sel != 0) ? {28'b0, b_instret} : a_instret;
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s %s instret: got %0d want %0d", phase, what, got, want);
        end
    endtask

    task automatic run_vectors();
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            imem_ready   = vq[i].ir;
            dmem_ready   = vq[i].dr;
            instr_op     = vq[i].op;
            instr_funct3 = vq[i].f3;
            #1;
            cmp_outs($sformatf("row %0d", i), vq[i].exp);
            cmp_cnt($sformatf("row %0d", i), exp_cnt & cnt_mask);
            if (vq[i].exp.retire) exp_cnt = exp_cnt + 32'd1;
        end
        vq.delete();
    endtask

    // Assert reset; optionally check the asynchronous clear before any clock edge.
    task automatic do_reset(input bit chk_now);
        reset = 1'b1;
        #1;
        if (chk_now) begin
            cmp_outs("async", '0);
            cmp_cnt("async", 32'd0);
        end
        @(posedge clk);
        #1;
        cmp_outs("held", '0);
        cmp_cnt("held", 32'd0);
        #1 reset = 1'b0;
        exp_cnt = 32'd0;
        push_any('0);
    endtask

    task automatic set_cfg(input int s);
        sel      = s;
        cur_to   = (s != 0) ? 0 : 4;
        cur_hoi  = (s == 0);
        cnt_mask = (s != 0) ? 32'h0000_000f : 32'hffff_ffff;
    endtask

    initial begin
        reset        = 1'b1;
        imem_ready   = 1'b0;
        dmem_ready   = 1'b0;
        instr_op     = '0;
        instr_funct3 = '0;
        exp_cnt      = 32'd0;
        pool_a = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                   7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
        pool_b = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                   7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1111111, 7'b0001111};
        set_cfg(0);

        phase = "addi";
        do_reset(1'b0);
        gen_instr(7'b0010011, 3'b000, 0, 0);
        run_vectors();

        phase = "lw_wait3";
        gen_instr(7'b0000011, 3'b010, 0, 3);
        run_vectors();

        phase = "sw_beq";
        do_reset(1'b0);
        gen_instr(7'b0100011, 3'b010, 0, 2);
        gen_instr(7'b1100011, 3'b000, 0, 0);
        run_vectors();

        phase = "rand_a";
        for (int n = 0; n < 30; n++) begin
            gen_instr(pool_a[$urandom_range(0, 8)], 3'($urandom),
                      $urandom_range(0, 4), $urandom_range(0, 4));
        end
        run_vectors();

        phase = "fetch_timeout";
        gen_instr(7'b0010011, 3'b000, 4, 0);
        gen_instr(7'b0000011, 3'b001, 0, 4);
        gen_instr(7'b0010011, 3'b000, 5, 0);
        run_vectors();

        phase = "mem_timeout";
        do_reset(1'b0);
        gen_instr(7'b0100011, 3'b000, 1, 5);
        run_vectors();

        phase = "illegal_fault";
        do_reset(1'b0);
        gen_instr(7'b1111111, 3'b000, 0, 0);
        run_vectors();

        phase = "ecall";
        do_reset(1'b0);
        gen_instr(7'b0010011, 3'b000, 0, 0);
        gen_instr(7'b1110011, 3'b000, 0, 0);
        run_vectors();

        set_cfg(1);
        phase = "illegal_nop";
        do_reset(1'b0);
        gen_instr(7'b1111111, 3'b000, 0, 0);
        gen_instr(7'b0010011, 3'b000, 0, 0);
        gen_instr(7'b0000011, 3'b000, 20, 12);
        run_vectors();

        phase = "rand_b";
        for (int n = 0; n < 40; n++) begin
            gen_instr(pool_b[$urandom_range(0, 10)], 3'($urandom),
                      $urandom_range(0, 7), $urandom_range(0, 7));
        end
        run_vectors();

        phase = "reset_mid_mem";
        do_reset(1'b0);
        gen_instr(7'b0010011, 3'b000, 0, 0);
        gen_instr(7'b0000011, 3'b100, 0, 5);
        for (int k = 0; k < 5; k++) void'(vq.pop_back());
        run_vectors();
        #2;
        do_reset(1'b1);
        gen_instr(7'b1100111, 3'b000, 0, 0);
        run_vectors();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
